// File: rtl/mm_pattern_master_if.sv
// Memory-mapped bus between the pattern master and a slave memory.
// Commands are held while waitrequest is high; read data returns one beat per read.
interface mm_pattern_master_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              read;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, write, writedata, read,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, write, writedata, read,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/mm_pattern_master.sv
// Test master: writes seed+i to BASE_ADDR+i for NUM_WORDS words, optionally
// reads them back and counts mismatches, with IDLE_CYCLES nops before each command.
module mm_pattern_master #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_WORDS   = 16,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned IDLE_CYCLES = 1,
    parameter int unsigned VERIFY      = 1
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     seed,
    mm_pattern_master_if.master   bus,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt
);
    typedef enum logic [2:0] {IDLE, WR_GAP, WR, RD_GAP, RD, RD_WAIT, DONE} state_e;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam logic [3:0]        GAP_LAST = 4'(IDLE_CYCLES - 1);
    localparam state_e            WR_ENTRY = (IDLE_CYCLES != 0) ? WR_GAP : WR;
    localparam state_e            RD_ENTRY = (IDLE_CYCLES != 0) ? RD_GAP : RD;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [3:0]        gap_q, gap_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [15:0]       err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              write_q, write_d;
    logic              read_q, read_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] exp_data;

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        gap_d    = gap_q;
        seed_d   = seed_q;
        err_d    = err_q;
        exp_data = seed_q + DATA_W'(index_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    seed_d  = seed;
                    err_d   = '0;
                    index_d = '0;
                    gap_d   = '0;
                    state_d = WR_ENTRY;
                end
            end
            WR_GAP, RD_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = (state_q == WR_GAP) ? WR : RD;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            WR: begin
                if (!bus.waitrequest) begin
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
                        state_d = (VERIFY != 0) ? RD_ENTRY : DONE;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        state_d = WR_ENTRY;
                    end
                end
            end
            RD: begin
                if (!bus.waitrequest) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.readdatavalid) begin
                    if (bus.readdata != exp_data && err_q != '1) err_d = err_q + 16'd1;
                    if (index_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        state_d = RD_ENTRY;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus outputs are derived from the next state so they are registered yet
        // line up with the state they belong to.
        write_d   = (state_d == WR);
        read_d    = (state_d == RD);
        address_d = (write_d || read_d) ? BASE + index_d : '0;
        wdata_d   = write_d ? seed_d + DATA_W'(index_d) : '0;
        busy_d    = !(state_d == IDLE || state_d == DONE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            index_q   <= '0;
            gap_q     <= '0;
            seed_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            gap_q     <= gap_d;
            seed_q    <= seed_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            write_q   <= write_d;
            read_q    <= read_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
        end
    end

    assign bus.address   = address_q;
    assign bus.write     = write_q;
    assign bus.writedata = wdata_q;
    assign bus.read      = read_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_cnt       = err_q;
endmodule

// File: tb/tb_mm_pattern_master.sv
// Bench for mm_pattern_master: three parameter sets, each driven by a randomized
// slave memory (stalls, read latency, corruption) and checked against pattern rules.
module tb_mm_pattern_master;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errs   = 0;
    int fin_cnt  = 0;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g_inst
        localparam int unsigned BASE = (k == 0) ? 0 : (k == 1) ? 'hFE : 'h30;
        localparam int unsigned NW   = (k == 2) ? 5 : 4;
        localparam int unsigned GAP  = (k == 0) ? 1 : (k == 1) ? 2 : 0;
        localparam int unsigned VER  = (k == 2) ? 0 : 1;

        logic        reset_i, start_i, busy_i, done_i;
        logic [7:0]  seed_i;
        logic [15:0] err_i;

        mm_pattern_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

        mm_pattern_master #(
            .ADDR_W(8), .DATA_W(8), .NUM_WORDS(NW), .BASE_ADDR(BASE),
            .IDLE_CYCLES(GAP), .VERIFY(VER)
        ) dut (
            .CLK(CLK), .reset(reset_i), .start(start_i), .seed(seed_i),
            .bus(bus), .busy(busy_i), .done(done_i), .err_cnt(err_i)
        );

        logic [7:0]  mem [256];
        logic        corrupt [256];
        logic [7:0]  wa_q[$];
        logic [7:0]  wd_q[$];
        int          busy_cycles, done_cnt, wr_stalls, rd_stalls, lat_sum;
        int          idle_bad, stable_bad, read_seen, rd_cnt, stall_pct, force_left;
        logic        force_armed, prev_wstall, prev_rstall;
        logic [7:0]  rd_addr, prev_addr, prev_wdata;
        logic [15:0] err_at_done;

        // Slave memory and monitor; everything happens mid-cycle, away from the DUT edge.
        always @(negedge CLK) begin
            if (reset_i) begin
                bus.waitrequest   = 1'b0;
                bus.readdatavalid = 1'b0;
                bus.readdata      = 8'h00;
                rd_cnt = 0; force_left = 0;
                prev_wstall = 1'b0; prev_rstall = 1'b0;
            end else begin
                if (prev_wstall && !(bus.write && bus.address == prev_addr && bus.writedata == prev_wdata))
                    stable_bad++;
                if (prev_rstall && !(bus.read && bus.address == prev_addr))
                    stable_bad++;
                if (busy_i) busy_cycles++;
                if (done_i) begin
                    done_cnt++;
                    err_at_done = err_i;
                end
                if (!busy_i && (bus.write || bus.read || bus.address != 8'h00 || bus.writedata != 8'h00))
                    idle_bad++;
                if (bus.read) read_seen++;

                if (force_armed && bus.write && bus.address == 8'(BASE + 1)) begin
                    force_armed = 1'b0;
                    force_left  = 3;
                end
                if (force_left > 0) begin
                    bus.waitrequest = 1'b1;
                    force_left--;
                end else begin
                    bus.waitrequest = ($urandom_range(1, 100) <= stall_pct);
                end

                prev_wstall = bus.write && bus.waitrequest;
                prev_rstall = bus.read && bus.waitrequest;
                prev_addr   = bus.address;
                prev_wdata  = bus.writedata;
                if (bus.write && bus.waitrequest) wr_stalls++;
                if (bus.read && bus.waitrequest) rd_stalls++;

                if (bus.write && !bus.waitrequest) begin
                    mem[bus.address] = bus.writedata;
                    wa_q.push_back(bus.address);
                    wd_q.push_back(bus.writedata);
                end

                if (rd_cnt > 0) begin
                    rd_cnt--;
                    bus.readdatavalid = (rd_cnt == 0);
                    bus.readdata      = mem[rd_addr] ^ (corrupt[rd_addr] ? 8'h5A : 8'h00);
                end else begin
                    // Stray valid beats with junk data must be ignored by the master.
                    bus.readdatavalid = ($urandom_range(0, 5) == 0);
                    bus.readdata      = 8'($urandom);
                end

                if (bus.read && !bus.waitrequest) begin
                    rd_cnt  = $urandom_range(1, 3);
                    rd_addr = bus.address;
                    lat_sum += rd_cnt;
                end
            end
        end

        initial begin
            logic [7:0] sd;
            int         exp_err, t;
            bit         ideal, abort_run, hold;

            reset_i = 1'b1; start_i = 1'b0; seed_i = 8'h00;
            stall_pct = 0; force_armed = 1'b0;
            for (int a = 0; a < 256; a++) corrupt[a] = 1'b0;
            repeat (2) @(posedge CLK);
            #2;
            check("rst_busy", busy_i, 0);
            check("rst_done", done_i, 0);
            check("rst_err", err_i, 0);
            check("rst_write", bus.write, 0);
            check("rst_read", bus.read, 0);
            check("rst_addr", bus.address, 0);
            reset_i = 1'b0;
            repeat (2) @(posedge CLK);
            #2;

            for (int r = 0; r < 5; r++) begin
                ideal       = (r < 2);
                abort_run   = (k == 0 && r == 2);
                hold        = (r == 4) || (k == 2 && r == 0);
                force_armed = (k == 0 && r == 0);
                stall_pct   = ideal ? 0 : 30;
                sd          = (k == 1 && r == 0) ? 8'hFF : (k == 0 && r == 0) ? 8'h10 : 8'($urandom);

                for (int a = 0; a < 256; a++) corrupt[a] = 1'b0;
                if (k == 0 && r == 1) corrupt[8'(BASE + 2)] = 1'b1;
                else if (!ideal)
                    for (int i = 0; i < NW; i++) corrupt[8'(BASE + i)] = ($urandom_range(0, 2) == 0);
                exp_err = 0;
                for (int i = 0; i < NW; i++) if (corrupt[8'(BASE + i)]) exp_err++;
                if (VER == 0) exp_err = 0;

                wa_q.delete(); wd_q.delete();
                busy_cycles = 0; done_cnt = 0; wr_stalls = 0; rd_stalls = 0; lat_sum = 0;
                idle_bad = 0; stable_bad = 0; read_seen = 0; err_at_done = 16'hDEAD;

                seed_i  = sd;
                start_i = 1'b1;
                @(posedge CLK);
                #2;
                if (!hold) start_i = 1'b0;

                if (abort_run) begin
                    t = 0;
                    while (!(wa_q.size() == 2 && bus.write) && t < 300) begin
                        @(posedge CLK);
                        #2;
                        t++;
                    end
                    check("abort_reach_word2", (t < 300), 1);
                    reset_i = 1'b1;
                    #1;
                    check("abort_write", bus.write, 0);
                    check("abort_read", bus.read, 0);
                    check("abort_busy", busy_i, 0);
                    check("abort_err", err_i, 0);
                    check("abort_addr", bus.address, 0);
                    @(posedge CLK);
                    #2;
                    reset_i = 1'b0;
                    @(posedge CLK);
                    #2;
                    continue;
                end

                t = 0;
                while (done_cnt == 0 && t < 400) begin
                    @(posedge CLK);
                    #2;
                    t++;
                end
                start_i = 1'b0;
                check("run_finished", (t < 400), 1);
                repeat (4) @(posedge CLK);
                #2;

                check("done_pulses", done_cnt, 1);
                check("busy_cycles", busy_cycles,
                      NW * (GAP + 1) * (VER != 0 ? 2 : 1) + wr_stalls + rd_stalls + lat_sum);
                check("write_count", wa_q.size(), NW);
                for (int i = 0; i < NW && i < wa_q.size(); i++) begin
                    check("write_addr", wa_q[i], 8'(BASE + i));
                    check("write_data", wd_q[i], 8'(sd + i));
                end
                check("read_cycles", read_seen, (VER != 0) ? NW + rd_stalls : 0);
                check("err_at_done", err_at_done, exp_err);
                check("err_hold", err_i, exp_err);
                check("idle_outputs", idle_bad, 0);
                check("stall_stable", stable_bad, 0);
                check("busy_after", busy_i, 0);
            end
            fin_cnt++;
        end
    end

    initial begin
        int t;
        t = 0;
        while (fin_cnt < 3 && t < 20000) begin
            @(posedge CLK);
            t++;
        end
        check("bench_complete", fin_cnt, 3);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
